// File: rtl/fifo_rd_packer.sv
// Read-side consumer for an 8-bit FIFO: issues single-byte reads, drops underflowed
// bytes, and packs good bytes little-endian into words offered on valid/ready.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int BACKOFF    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      fifo_data_out,
  input  logic                       fifo_under_flow,
  output logic                       fifo_rd_n,
  output logic [DATA_WIDTH*PACK-1:0] word_data,
  output logic [PACK-1:0]            word_keep,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [7:0]                 uf_count,
  output logic                       busy
);

  localparam int WORD_W = DATA_WIDTH * PACK;
  localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK - 1);

  typedef enum logic [1:0] {IDLE, RD, CHK, BACK} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [3:0]          timer, timer_d;
  logic [WORD_W-1:0]   lanes, lanes_d;
  logic                load;
  logic [WORD_W-1:0]   load_data;
  logic [PACK-1:0]     load_keep;
  logic                valid_d;
  logic                valid_chk;
  logic                uf_inc;

  function automatic logic [PACK-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [PACK-1:0] m;
    m = '0;
    for (int i = 0; i < PACK; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] d,
                                                  input logic [PACK-1:0]   k);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < PACK; i++)
      if (k[i]) w[i*DATA_WIDTH +: DATA_WIDTH] = d[i*DATA_WIDTH +: DATA_WIDTH];
    return w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A read may only start if a completed word could still be loaded afterwards.
  function automatic logic room(input logic v, input logic [CNT_W-1:0] c);
    return !(v && (c == LAST));
  endfunction

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    timer_d   = timer;
    lanes_d   = lanes;
    load      = 1'b0;
    load_data = lanes;
    load_keep = '0;
    uf_inc    = 1'b0;
    valid_chk = 1'b0;
    valid_d   = word_valid && !word_ready;
    case (state)
      IDLE: begin
        if (flush && (cnt != '0) && !word_valid) begin
          load      = 1'b1;
          load_keep = keep_mask(cnt);
          load_data = mask_word(lanes, load_keep);
          cnt_d     = '0;
        end else if (en && !flush && room(word_valid, cnt)) begin
          state_d = RD;
        end
      end
      RD: state_d = CHK;
      CHK: begin
        if (!fifo_under_flow) begin
          lanes_d[cnt*DATA_WIDTH +: DATA_WIDTH] = fifo_data_out;
          if (cnt == LAST) begin
            load      = 1'b1;
            load_keep = '1;
            load_data = lanes_d;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
          valid_chk = load || (word_valid && !word_ready);
          state_d   = (en && !flush && room(valid_chk, cnt_d)) ? RD : IDLE;
        end else begin
          uf_inc  = 1'b1;
          timer_d = 4'(BACKOFF);
          state_d = BACK;
        end
      end
      BACK: begin
        timer_d = timer - 4'd1;
        if (timer <= 4'd1) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      timer      <= '0;
      fifo_rd_n  <= 1'b1;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_keep  <= '0;
      uf_count   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      timer      <= timer_d;
      fifo_rd_n  <= (state_d != RD);
      word_valid <= valid_d;
      if (load) begin
        word_data <= load_data;
        word_keep <= load_keep;
      end
      if (uf_inc) uf_count <= sat_inc(uf_count);
    end
  end

  // Lane storage is always masked by cnt on output, so it needs no reset.
  always_ff @(posedge clk) begin
    lanes <= lanes_d;
  end

  assign busy = (state != IDLE) || (cnt != '0);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO behavioural model feeds bytes, a byte-stream
// reference builds expected words, and a monitor checks every accepted word.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PACK = 4;
  localparam int BACKOFF = 2;

  typedef struct {
    logic [DW*PACK-1:0] d;
    logic [PACK-1:0]    k;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic flush = 1'b0;
  logic [DW-1:0] fifo_data_out = '0;
  logic fifo_under_flow = 1'b0;
  logic fifo_rd_n;
  logic [DW*PACK-1:0] word_data;
  logic [PACK-1:0] word_keep;
  logic word_valid;
  logic word_ready = 1'b0;
  logic [7:0] uf_count;
  logic busy;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PACK), .BACKOFF(BACKOFF)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .fifo_data_out(fifo_data_out), .fifo_under_flow(fifo_under_flow),
    .fifo_rd_n(fifo_rd_n), .word_data(word_data), .word_keep(word_keep),
    .word_valid(word_valid), .word_ready(word_ready),
    .uf_count(uf_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int uf_n = 0;
  int words_seen = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] acc[$];
  word_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: good bytes concatenate in read order; every PACK bytes make a word.
  function automatic word_t make_word();
    word_t w;
    w.d = '0;
    w.k = '0;
    for (int i = 0; i < acc.size(); i++) begin
      w.d[i*DW +: DW] = acc[i];
      w.k[i] = 1'b1;
    end
    return w;
  endfunction

  // FIFO model: a low strobe in a cycle pops at the edge ending it.
  initial begin
    logic rdl, prev_low;
    prev_low = 1'b0;
    forever begin
      @(negedge clk);
      rdl = !fifo_rd_n;
      if (rdl) check("rd_n_not_consecutive", {63'd0, prev_low}, 64'd0);
      prev_low = rdl;
      @(posedge clk);
      #1;
      if (rdl && !rst) begin
        pulses++;
        pulse_cyc = cyc;
        if (fifo_q.size() == 0) begin
          fifo_under_flow = 1'b1;
          uf_n++;
        end else begin
          fifo_data_out = fifo_q.pop_front();
          fifo_under_flow = 1'b0;
          acc.push_back(fifo_data_out);
          if (acc.size() == PACK) begin
            exp_q.push_back(make_word());
            acc.delete();
          end
        end
      end
    end
  end

  // Monitor: compares accepted words and checks stability while stalled.
  initial begin
    logic stalled;
    logic [DW*PACK-1:0] held_d;
    logic [PACK-1:0] held_k;
    word_t w;
    stalled = 1'b0;
    held_d = '0;
    held_k = '0;
    forever begin
      @(negedge clk);
      if (rst || !word_valid) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("held_data", {32'd0, word_data}, {32'd0, held_d});
          check("held_keep", {60'd0, word_keep}, {60'd0, held_k});
        end
        if (word_ready) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", {32'd0, word_data}, 64'hDEAD_0000_0000);
          end else begin
            w = exp_q.pop_front();
            check("word_data", {32'd0, word_data}, {32'd0, w.d});
            check("word_keep", {60'd0, word_keep}, {60'd0, w.k});
          end
        end
        stalled = !word_ready;
        held_d = word_data;
        held_k = word_keep;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    tick(2);
    rst = 1'b0;
    acc.delete();
    exp_q.delete();
    fifo_q.delete();
    uf_n = 0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (pulses < target && n < budget) begin
      tick(1);
      n++;
    end
    if (pulses < target) check("pulse_timeout", 64'(pulses), 64'(target));
  endtask

  // Only called when the block is quiescent, so the reference knows cnt exactly.
  task automatic do_flush();
    flush = 1'b1;
    if (acc.size() > 0) begin
      exp_q.push_back(make_word());
      acc.delete();
    end
    tick(1);
    flush = 1'b0;
  endtask

  function automatic int uf_exp();
    return (uf_n > 255) ? 255 : uf_n;
  endfunction

  initial begin
    int p0, c1, c2, w0, nlow;
    // Reset values
    tick(3);
    rst = 1'b0;
    check("rst_rd_n", 64'(fifo_rd_n), 64'd1);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_data", 64'(word_data), 64'd0);
    check("rst_keep", 64'(word_keep), 64'd0);
    check("rst_uf", 64'(uf_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Full-word latency
    do_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    p0 = pulses;
    word_ready = 1'b1;
    en = 1'b1;
    tick(7);
    en = 1'b0;
    tick(1);
    check("lat_valid_c8", 64'(word_valid), 64'd0);
    tick(1);
    check("lat_valid_c9", 64'(word_valid), 64'd1);
    check("lat_data", 64'(word_data), 64'h4433_2211);
    check("lat_keep", 64'(word_keep), 64'hF);
    check("lat_pulses", 64'(pulses - p0), 64'd4);
    tick(5);

    // Underflow back-off spacing and saturation
    do_reset();
    p0 = pulses;
    en = 1'b1;
    wait_pulses(p0 + 1, 20);
    c1 = pulse_cyc;
    tick(2);
    check("uf_first", 64'(uf_count), 64'd1);
    wait_pulses(p0 + 2, 20);
    c2 = pulse_cyc;
    check("uf_spacing", 64'(c2 - c1), 64'(3 + BACKOFF));
    wait_pulses(p0 + 300, 3000);
    en = 1'b0;
    tick(10);
    check("uf_sat", 64'(uf_count), 64'd255);
    check("uf_model", 64'(uf_count), 64'(uf_exp()));

    // Partial flush
    do_reset();
    fifo_q = '{8'hA1, 8'hB2};
    en = 1'b1;
    tick(12);
    en = 1'b0;
    tick(12);
    check("flush_busy_before", 64'(busy), 64'd1);
    do_flush();
    check("flush_valid", 64'(word_valid), 64'd1);
    check("flush_data", 64'(word_data), 64'h0000_B2A1);
    check("flush_keep", 64'(word_keep), 64'h3);
    check("flush_busy_after", 64'(busy), 64'd0);
    tick(3);
    w0 = words_seen;
    do_flush();
    tick(4);
    check("flush2_nothing", 64'(words_seen - w0), 64'd0);

    // Backpressure: room rule halts reads
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h50 + i));
    p0 = pulses;
    en = 1'b1;
    tick(40);
    check("bp_pulses", 64'(pulses - p0), 64'd7);
    check("bp_left", 64'(fifo_q.size()), 64'd1);
    check("bp_valid", 64'(word_valid), 64'd1);
    nlow = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!fifo_rd_n) nlow++;
    end
    check("bp_rd_idle", 64'(nlow), 64'd0);
    tick(1);
    word_ready = 1'b1;
    tick(20);
    en = 1'b0;
    tick(10);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset during CHK with two bytes packed
    do_reset();
    fifo_q = '{8'h01, 8'h02, 8'h03};
    en = 1'b1;
    nlow = 0;
    for (int i = 0; i < 40 && nlow < 3; i++) begin
      @(negedge clk);
      if (!fifo_rd_n) nlow++;
    end
    check("rstchk_reached", 64'(nlow), 64'd3);
    tick(1);
    rst = 1'b1;
    en = 1'b0;
    tick(1);
    check("rstchk_rd_n", 64'(fifo_rd_n), 64'd1);
    check("rstchk_valid", 64'(word_valid), 64'd0);
    check("rstchk_data", 64'(word_data), 64'd0);
    check("rstchk_keep", 64'(word_keep), 64'd0);
    check("rstchk_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    acc.delete();
    exp_q.delete();
    uf_n = 0;
    tick(8);
    check("rstchk_no_word", 64'(word_valid), 64'd0);

    // Back-to-back words
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'hC0 + i));
    w0 = words_seen;
    p0 = pulses;
    en = 1'b1;
    wait_pulses(p0 + 16, 200);
    tick(6);
    en = 1'b0;
    tick(10);
    check("b2b_words", 64'(words_seen - w0), 64'd4);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      word_ready = ($urandom_range(0, 2) != 0);
      if (fifo_q.size() < 16 && $urandom_range(0, 2) == 0)
        fifo_q.push_back(8'($urandom));
      tick(1);
    end
    en = 1'b0;
    word_ready = 1'b1;
    tick(20);
    do_flush();
    tick(10);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_uf", 64'(uf_count), 64'(uf_exp()));
    check("rand_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
